// File: rtl/stream_reader_if.sv
// Memory read port plus valid/ready output stream of stream_reader.
// master = the reader, slave = the buffer and the downstream consumer.
interface stream_reader_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 10
) ();
   logic                    mem_rd_en;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic signed [WIDTH-1:0] mem_rd_data;
   logic                    m_valid;
   logic                    m_ready;
   logic signed [WIDTH-1:0] m_data;
   logic                    m_last;

   modport master (
      output mem_rd_en, mem_addr, m_valid, m_data, m_last,
      input  mem_rd_data, m_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, m_valid, m_data, m_last,
      output mem_rd_data, m_ready
   );
endinterface

// File: rtl/stream_reader.sv
// stream_reader: walks base_addr..base_addr+length-1 of a 1-cycle-latency buffer and streams the words
// through a 2-entry skid FIFO. Defining STREAM_READER_ABORT_EN adds an abort input that cancels a run.
module stream_reader #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
`ifdef STREAM_READER_ABORT_EN
   input  logic                  abort,
`endif
   stream_reader_if.master       bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;

   state_t                  r_state;
   logic                    r_busy;
   logic                    r_done;
   logic [ADDR_WIDTH:0]     r_issue_cnt;
   logic [ADDR_WIDTH-1:0]   r_rd_ptr;
   logic                    r_vld;
   logic                    r_vld_last;
   logic                    r_wr_idx;
   logic                    r_rd_idx;
   logic [1:0]              r_count;

   logic                    w_abort;
   logic                    w_valid;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_issue;
   logic                    w_last_pop;
   logic [2:0]              w_credit;
   logic signed [WIDTH-1:0] w_entry_data [2];
   logic                    w_entry_last [2];

`ifdef STREAM_READER_ABORT_EN
   assign w_abort = abort && (r_state == S_RUN);
`else
   assign w_abort = 1'b0;
`endif

   assign w_valid    = (r_count != 2'd0);
   assign w_push     = r_vld;
   assign w_pop      = w_valid && bus.m_ready;
   assign w_last_pop = w_pop && w_entry_last[r_rd_idx];

   // Words that will occupy the FIFO once the in-flight read lands; one slot must stay free for a new read.
   assign w_credit = {1'b0, r_count} + {2'b00, r_vld} - {2'b00, w_pop};
   assign w_issue  = (r_state == S_RUN) && (r_issue_cnt != '0) && (w_credit <= 3'd1) && !w_abort;

   always_ff @(posedge clk) begin
      if (rst || w_abort) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_issue_cnt <= '0;
         r_rd_ptr    <= '0;
         r_vld       <= 1'b0;
         r_vld_last  <= 1'b0;
         r_wr_idx    <= 1'b0;
         r_rd_idx    <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_vld      <= w_issue;
         r_vld_last <= w_issue && (r_issue_cnt == {{ADDR_WIDTH{1'b0}}, 1'b1});
         if (w_issue) begin
            r_issue_cnt <= r_issue_cnt - 1'b1;
            r_rd_ptr    <= r_rd_ptr + 1'b1;
         end
         if (w_push) r_wr_idx <= ~r_wr_idx;
         if (w_pop)  r_rd_idx <= ~r_rd_idx;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_issue_cnt <= length;
                  r_rd_ptr    <= base_addr;
                  r_busy      <= 1'b1;
                  if (length == '0) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_last_pop) begin
                  r_state <= S_FINISH;
                  r_done  <= 1'b1;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic signed [WIDTH-1:0] r_data;
         logic                    r_last;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_data <= '0;
               r_last <= 1'b0;
            end else if (w_push && (r_wr_idx == 1'(gi))) begin
               r_data <= bus.mem_rd_data;
               r_last <= r_vld_last;
            end
         end
         assign w_entry_data[gi] = r_data;
         assign w_entry_last[gi] = r_last;
      end
   endgenerate

   assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == 2'd2)));

   assign busy          = r_busy;
   assign done          = r_done;
   assign bus.mem_rd_en = w_issue;
   assign bus.mem_addr  = r_rd_ptr;
   assign bus.m_valid   = w_valid;
   // Stale entries stay hidden so an empty FIFO presents zeros.
   assign bus.m_data    = w_valid ? w_entry_data[r_rd_idx] : '0;
   assign bus.m_last    = w_valid && w_entry_last[r_rd_idx];
endmodule

// File: tb/tb_stream_reader.sv
// tb_stream_reader: directed and randomized bench for stream_reader against a queue-based model;
// abort scenarios are compiled in only with STREAM_READER_ABORT_EN.
module tb_stream_reader;
   localparam int WIDTH = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic signed [WIDTH-1:0] d;
      logic                    l;
   } word_t;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          start     = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length    = '0;
   logic          busy;
   logic          done;
`ifdef STREAM_READER_ABORT_EN
   logic          abort     = 1'b0;
`endif

   stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   stream_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
`ifdef STREAM_READER_ABORT_EN
      .abort     (abort),
`endif
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic signed [WIDTH-1:0] mem [DEPTH];

   // Buffer model; read data is garbage except in the cycle after a read.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
      else               bus.mem_rd_data <= WIDTH'($urandom);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: expected word queue, FIFO fill count, busy/done from the run rules.
   word_t                   exp_q[$];
   logic                    mdl_busy   = 1'b0;
   logic                    mdl_done   = 1'b0;
   int                      occ        = 0;
   logic                    rd_d1      = 1'b0;
   int                      reads      = 0;
   int                      mdl_len    = 0;
   logic [AW-1:0]           exp_addr   = '0;
   int                      acc_cnt    = 0;
   logic                    prev_stall = 1'b0;
   logic signed [WIDTH-1:0] prev_data  = '0;
   logic                    prev_last  = 1'b0;

   always @(negedge clk) begin
      logic  hs;
      logic  kill;
      logic  new_done;
      word_t w;
      chk("busy", busy, int'(mdl_busy));
      chk("done", done, int'(mdl_done));
      chk("valid_vs_fill", bus.m_valid, int'(occ != 0));
      chk("fill_le_2", int'(occ <= 2), 1);
      if (prev_stall) begin
         chk("hold_data", bus.m_data, int'(prev_data));
         chk("hold_last", bus.m_last, int'(prev_last));
      end
      if (bus.m_valid) begin
         chk("word_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            chk("data", bus.m_data, int'($signed(exp_q[0].d)));
            chk("last", bus.m_last, int'(exp_q[0].l));
         end
      end
      if (bus.mem_rd_en) begin
         chk("rd_addr", {28'd0, bus.mem_addr}, int'(exp_addr));
         chk("rd_within_length", int'(reads < mdl_len), 1);
      end
      if (mdl_done) chk("reads_total", reads, mdl_len);

      hs = bus.m_valid && bus.m_ready;
`ifdef STREAM_READER_ABORT_EN
      kill = abort && mdl_busy && !mdl_done;
`else
      kill = 1'b0;
`endif
      if (hs) acc_cnt++;
      if (rst || kill) begin
         exp_q.delete();
         mdl_busy   = 1'b0;
         mdl_done   = 1'b0;
         occ        = 0;
         rd_d1      = 1'b0;
         reads      = 0;
         mdl_len    = 0;
         prev_stall = 1'b0;
      end else begin
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         occ        = occ + int'(rd_d1) - int'(hs);
         rd_d1      = bus.mem_rd_en;
         if (bus.mem_rd_en) begin
            reads++;
            exp_addr++;
         end
         new_done = 1'b0;
         if (hs && exp_q.size() != 0) begin
            new_done = exp_q[0].l;
            void'(exp_q.pop_front());
         end
         if (mdl_done) begin
            mdl_busy = 1'b0;
         end else if (!mdl_busy && start) begin
            mdl_busy = 1'b1;
            mdl_len  = int'(length);
            reads    = 0;
            exp_addr = base_addr;
            exp_q.delete();
            for (int i = 0; i < mdl_len; i++) begin
               w.d = mem[(int'(base_addr) + i) % DEPTH];
               w.l = (i == mdl_len - 1);
               exp_q.push_back(w);
            end
            if (mdl_len == 0) new_done = 1'b1;
         end
         mdl_done = new_done;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Pulses start in "cycle 0"; returns 1 time unit into cycle 1.
   task automatic do_start(input int b, input int len);
      next_cycle();
      start        = 1'b1;
      base_addr    = b[AW-1:0];
      length       = len[AW:0];
      bus.m_ready  = 1'b1;
      $display("start base=%0d length=%0d", b, len);
      next_cycle();
      start     = 1'b0;
      base_addr = AW'($urandom);
      length    = (AW+1)'($urandom);
   endtask

   // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready plus stray starts mid-run.
   task automatic wait_idle(input int mode, input int budget);
      int   n;
      bit   ok;
      logic d;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         d = done;
         if (!busy) begin
            ok = 1'b1;
         end else begin
            next_cycle();
            n++;
            start = 1'b0;
            case (mode)
               1: bus.m_ready = (n % 4 == 0) || (n % 4 == 3);
               2: begin
                  bus.m_ready = ($urandom_range(0, 3) != 0);
                  if (!d && $urandom_range(0, 7) == 0) start = 1'b1;
               end
               default: bus.m_ready = 1'b1;
            endcase
         end
      end
      start = 1'b0;
      chk("idle_within_budget", int'(ok), 1);
   endtask

   initial begin
      int acc0;
      int b;
      int len;
      int addrs[$];
      int exp_wrap[4];
      bus.m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i - 8);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_valid", bus.m_valid, 0);
      chk("reset_last", bus.m_last, 0);
      chk("reset_data", bus.m_data, 0);
      chk("reset_rd_en", bus.mem_rd_en, 0);
      chk("reset_addr", {28'd0, bus.mem_addr}, 0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Basic streaming: words -4..0 in cycles 3..7, done in cycle 8.
      do_start(4, 5);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk("basic_valid", bus.m_valid, int'(k >= 3 && k <= 7));
         if (k >= 3 && k <= 7) chk("basic_data", bus.m_data, k - 7);
         chk("basic_last", bus.m_last, int'(k == 7));
         chk("basic_done", done, int'(k == 8));
         chk("basic_busy", busy, int'(k <= 8));
         chk("basic_rd_en", bus.mem_rd_en, int'(k <= 5));
         if (k <= 5) chk("basic_addr", {28'd0, bus.mem_addr}, k + 3);
         next_cycle();
      end

      // Back-pressure.
      acc0 = acc_cnt;
      do_start(2, 6);
      wait_idle(1, 100);
      chk("backpressure_words", acc_cnt - acc0, 6);

      // Address wrap.
      exp_wrap = '{14, 15, 0, 1};
      addrs.delete();
      do_start(14, 4);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.mem_rd_en) addrs.push_back(int'(bus.mem_addr));
         next_cycle();
      end
      chk("wrap_reads", addrs.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < addrs.size()) chk("wrap_addr", addrs[i], exp_wrap[i]);
      wait_idle(0, 50);

      // Zero length.
      do_start(7, 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("zero_done", done, int'(k == 1));
         chk("zero_valid", bus.m_valid, 0);
         chk("zero_rd_en", bus.mem_rd_en, 0);
         next_cycle();
      end

      // Start while running is ignored.
      acc0 = acc_cnt;
      do_start(3, 5);
      @(negedge clk);
      next_cycle();
      start     = 1'b1;
      base_addr = 4'd9;
      length    = 5'd2;
      next_cycle();
      start = 1'b0;
      wait_idle(0, 50);
      chk("ignored_start_words", acc_cnt - acc0, 5);

      // Reset in cycle 5 of a 10-word run.
      do_start(0, 10);
      repeat (4) begin
         @(negedge clk);
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (4) begin
         next_cycle();
         @(negedge clk);
         chk("rst_no_done", done, 0);
      end
      acc0 = acc_cnt;
      do_start(5, 3);
      wait_idle(0, 50);
      chk("post_rst_words", acc_cnt - acc0, 3);

`ifdef STREAM_READER_ABORT_EN
      // Abort in cycle 6 of a 10-word run, then a 2-word run from address 0.
      do_start(0, 10);
      repeat (5) begin
         @(negedge clk);
         next_cycle();
      end
      abort = 1'b1;
      next_cycle();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", bus.m_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (4) begin
         next_cycle();
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      do_start(0, 2);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("post_abort_valid", bus.m_valid, int'(k == 3 || k == 4));
         if (k == 3 || k == 4) chk("post_abort_data", bus.m_data, k - 11);
         next_cycle();
      end
`endif

      // Randomized runs, including the full-buffer length.
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
         len  = (r == 0) ? DEPTH : int'($urandom_range(0, DEPTH));
         b    = int'($urandom_range(0, DEPTH - 1));
         acc0 = acc_cnt;
         do_start(b, len);
         wait_idle(2, 400);
         chk("random_words", acc_cnt - acc0, len);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
